stats_registers_controller: RTL and testbench
=============================================

Name: stats_registers_controller

Overview:
- Parametrised, multi-channel successor to the single-counter register controller.
- Avalon-MM slave block:
  - NUM_CH per-channel message counters with selectable wrap or saturate mode.
  - Sticky per-channel overflow flags (write-1-to-clear), optional clear-on-read, and a global clear.
  - NUM_SCRATCH read/write debug registers.
- Sits on the loopback control bus next to the datapath; each datapath channel drives one msg_enter bit.

Parameters:
- ADDR_BASE, 0, word address of register window start; window is 64 words.
- NUM_CH, 4, number of counter channels, 1..16.
- CNT_W, 32, counter width, 1..DATA_W.
- DATA_W, 32, Avalon data width.
- ADDR_W, 16, Avalon word-address width.
- NUM_SCRATCH, 2, number of scratch registers, 1..12.
- REG_ID, 32'h5354_0001, constant returned by the ID register.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- msg_enter  in  NUM_CH  per-channel count strobe; one increment per cycle while high
- reg_address  in  ADDR_W  word address
- reg_write  in  1  write strobe
- reg_writedata  in  DATA_W  write data
- reg_read  in  1  read strobe
- reg_readdata  out  DATA_W  read data
- reg_readdatavalid  out  1  read data qualifier
- reg_waitrequest  out  1  tied 0
- irq  out  1  OR of (STATUS & IRQ_MASK)

Behaviour:
- Clock and reset:
  - Single clock clk; reset rst is synchronous, active-high.
  - Reset values: reg_readdata 0, reg_readdatavalid 0, irq 0, counters 0, STATUS 0, IRQ_MASK 0, scratch 0.
  - CTRL resets to enable=1, clear_on_read=0, saturate=0.
- Register map, word offsets from ADDR_BASE:
  - 0x00 ID, RO, returns REG_ID.
  - 0x01 CTRL, RW.
    - bit0 enable.
    - bit1 clear_on_read.
    - bit2 saturate (1 = saturate, 0 = wrap).
    - bit3 clear_all: write-1 pulse, reads 0.
  - 0x02 STATUS: bit ch = overflow sticky; write-1-to-clear.
  - 0x03 IRQ_MASK, RW, NUM_CH bits.
  - 0x04..0x04+NUM_SCRATCH-1 scratch, RW, full DATA_W.
  - 0x20+ch counter ch, RO, zero-extended to DATA_W.
  - Other in-window offsets read 0; writes to them are ignored.
- Decode:
  - A request is in-window when ADDR_BASE <= reg_address < ADDR_BASE+64.
  - Out-of-window reads and writes are ignored entirely: no readdatavalid.
- Read timing:
  - Fixed read latency 1: reg_read sampled high in cycle N gives reg_readdatavalid=1 and data in cycle N+1.
  - reg_readdatavalid is a one-cycle pulse per read; back-to-back reads are supported every cycle.
  - reg_readdata holds its last value when not valid.
- Write timing: a write takes effect at the clock edge where reg_write is sampled.
- Simultaneous read and write in the same cycle: both are processed; the read returns the pre-write value.
- Counting:
  - Counter ch increments when msg_enter[ch] && enable.
  - At all-ones with an increment:
    - wrap mode: goes to 0 and sets STATUS[ch];
    - saturate mode: holds all-ones and sets STATUS[ch].
- Clear-on-read:
  - A read of counter ch returns the current value.
  - At the same edge the counter becomes msg_enter[ch]&&enable ? 1 : 0; no increment is lost.
- clear_all:
  - Zeroes all counters and STATUS at the write edge.
  - Has priority over increments and overflow set in that cycle.
- STATUS priority: a same-cycle overflow set beats a W1C clear on that bit.
- irq is registered: it reflects STATUS/IRQ_MASK one cycle after they change.
- Reset asserted mid-read: no readdatavalid is produced for the dropped read.

Decomposition:
- Package stats_regs_pkg:
  - offset localparams OFF_ID, OFF_CTRL, OFF_STATUS, OFF_IRQ_MASK, OFF_SCRATCH0, OFF_CNT0;
  - CTRL bit-index constants;
  - WINDOW_WORDS=64.
- Sub-module stats_counter, one per channel via generate.
  - Inputs: inc, clr, rd_clr, saturate.
  - Outputs: value, ovf_pulse.
- The top level holds decode, CTRL/STATUS/scratch, and the read mux.

Test Plan:
- Reset, then read 0x00 -> readdatavalid exactly one cycle later with 0x5354_0001; reading 0x05 right after reset -> 0.
- Write 0xDEADBEEF to scratch 0x04, read back -> 0xDEADBEEF; write to 0x3F then read 0x3F -> 0; address ADDR_BASE+64 read -> no readdatavalid.
- msg_enter[1]=1 for 10 cycles, enable=1 -> counter 0x21 reads 10 and counter 0x20 reads 0; repeat with enable=0 -> still 10.
- CNT_W=4, wrap mode, 17 increments -> counter 1 and STATUS[0]=1; saturate mode, 17 increments -> 15 and STATUS[0]=1; IRQ_MASK=1 -> irq=1; W1C 0x1 to STATUS -> irq drops one cycle later.
- clear_on_read=1 with continuous msg_enter[0] -> consecutive reads return the counter value, then exactly the cycles elapsed since the previous read.
- Write clear_all while msg_enter is all-ones -> all counters read 0 on the next read cycle; assert rst during a pending read -> no readdatavalid.

Source files
------------

// File: rtl/stats_registers_controller_pkg.sv
// Register map offsets and CTRL bit positions shared by the stats register block.
package stats_regs_pkg;
    localparam int WINDOW_WORDS = 64;

    localparam logic [5:0] OFF_ID       = 6'h00;
    localparam logic [5:0] OFF_CTRL     = 6'h01;
    localparam logic [5:0] OFF_STATUS   = 6'h02;
    localparam logic [5:0] OFF_IRQ_MASK = 6'h03;
    localparam logic [5:0] OFF_SCRATCH0 = 6'h04;
    localparam logic [5:0] OFF_CNT0     = 6'h20;

    localparam int CTRL_ENABLE    = 0;
    localparam int CTRL_CLR_ON_RD = 1;
    localparam int CTRL_SATURATE  = 2;
    localparam int CTRL_CLEAR_ALL = 3;
endpackage

// File: rtl/stats_registers_controller_if.sv
// Avalon-MM register bus between a control master and the stats register block.
interface stats_registers_controller_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] reg_address;
    logic              reg_write;
    logic [DATA_W-1:0] reg_writedata;
    logic              reg_read;
    logic [DATA_W-1:0] reg_readdata;
    logic              reg_readdatavalid;
    logic              reg_waitrequest;

    modport master (
        output reg_address, reg_write, reg_writedata, reg_read,
        input  reg_readdata, reg_readdatavalid, reg_waitrequest
    );
    modport slave (
        input  reg_address, reg_write, reg_writedata, reg_read,
        output reg_readdata, reg_readdatavalid, reg_waitrequest
    );
endinterface

// File: rtl/stats_registers_controller_counter.sv
// One message counter channel: wrap or saturate at all-ones, clear-on-read keeps same-cycle increment.
module stats_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    input  logic             rd_clr,
    input  logic             saturate,
    output logic [CNT_W-1:0] value,
    output logic             ovf_pulse
);
    logic all_ones;

    assign all_ones  = &value;
    // A clear-on-read restarts the count, so the increment lands in the fresh value instead of wrapping.
    assign ovf_pulse = inc && all_ones && !clr && !rd_clr;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value <= '0;
        end else if (rd_clr) begin
            value <= inc ? CNT_W'(1) : '0;
        end else if (inc) begin
            if (!all_ones)
                value <= value + CNT_W'(1);
            else if (!saturate)
                value <= '0;
        end
    end
endmodule

// File: rtl/stats_registers_controller.sv
// Multi-channel message counter register block on an Avalon-MM slave bus.
module stats_registers_controller
    import stats_regs_pkg::*;
#(
    parameter int          ADDR_BASE   = 0,
    parameter int          NUM_CH      = 4,
    parameter int          CNT_W       = 32,
    parameter int          DATA_W      = 32,
    parameter int          ADDR_W      = 16,
    parameter int          NUM_SCRATCH = 2,
    parameter logic [31:0] REG_ID      = 32'h5354_0001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] msg_enter,
    stats_registers_controller_if.slave bus,
    output logic              irq
);
    logic [ADDR_W-1:0]                  off;
    logic [5:0]                         off6;
    logic                               in_win, rd, wr, clear_all;
    logic                               enable, clr_on_rd, saturate;
    logic [NUM_CH-1:0]                  status, irq_mask, inc, rd_clr, ovf;
    logic [NUM_CH-1:0][CNT_W-1:0]       cnt;
    logic [NUM_SCRATCH-1:0][DATA_W-1:0] scratch;
    logic [DATA_W-1:0]                  rdata_next;

    assign off       = bus.reg_address - ADDR_W'(ADDR_BASE);
    assign off6      = off[5:0];
    assign in_win    = (bus.reg_address >= ADDR_W'(ADDR_BASE)) && (off < ADDR_W'(WINDOW_WORDS));
    assign rd        = bus.reg_read && in_win;
    assign wr        = bus.reg_write && in_win;
    assign clear_all = wr && (off6 == OFF_CTRL) && bus.reg_writedata[CTRL_CLEAR_ALL];

    assign bus.reg_waitrequest = 1'b0;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        assign inc[ch]    = msg_enter[ch] && enable;
        assign rd_clr[ch] = rd && clr_on_rd && (off6 == 6'(OFF_CNT0 + ch));
        stats_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (inc[ch]),
            .clr       (clear_all),
            .rd_clr    (rd_clr[ch]),
            .saturate  (saturate),
            .value     (cnt[ch]),
            .ovf_pulse (ovf[ch])
        );
    end

    // Read mux sees pre-write register state, so a same-cycle read returns the old value.
    always_comb begin
        rdata_next = '0;
        case (off6)
            OFF_ID: rdata_next = DATA_W'(REG_ID);
            OFF_CTRL: begin
                rdata_next[CTRL_ENABLE]    = enable;
                rdata_next[CTRL_CLR_ON_RD] = clr_on_rd;
                rdata_next[CTRL_SATURATE]  = saturate;
            end
            OFF_STATUS:   rdata_next[NUM_CH-1:0] = status;
            OFF_IRQ_MASK: rdata_next[NUM_CH-1:0] = irq_mask;
            default: ;
        endcase
        for (int s = 0; s < NUM_SCRATCH; s++)
            if (off6 == 6'(OFF_SCRATCH0 + s)) rdata_next = scratch[s];
        for (int ch = 0; ch < NUM_CH; ch++)
            if (off6 == 6'(OFF_CNT0 + ch)) begin
                rdata_next              = '0;
                rdata_next[CNT_W-1:0]   = cnt[ch];
            end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enable                <= 1'b1;
            clr_on_rd             <= 1'b0;
            saturate              <= 1'b0;
            status                <= '0;
            irq_mask              <= '0;
            scratch               <= '0;
            irq                   <= 1'b0;
            bus.reg_readdata      <= '0;
            bus.reg_readdatavalid <= 1'b0;
        end else begin
            bus.reg_readdatavalid <= rd;
            if (rd) bus.reg_readdata <= rdata_next;
            if (wr && off6 == OFF_CTRL) begin
                enable    <= bus.reg_writedata[CTRL_ENABLE];
                clr_on_rd <= bus.reg_writedata[CTRL_CLR_ON_RD];
                saturate  <= bus.reg_writedata[CTRL_SATURATE];
            end
            if (wr && off6 == OFF_IRQ_MASK) irq_mask <= bus.reg_writedata[NUM_CH-1:0];
            for (int s = 0; s < NUM_SCRATCH; s++)
                if (wr && off6 == 6'(OFF_SCRATCH0 + s)) scratch[s] <= bus.reg_writedata;
            // Overflow set wins over a same-cycle W1C; clear_all wins over both.
            if (clear_all)
                status <= '0;
            else if (wr && off6 == OFF_STATUS)
                status <= (status & ~bus.reg_writedata[NUM_CH-1:0]) | ovf;
            else
                status <= status | ovf;
            irq <= |(status & irq_mask);
        end
    end
endmodule

// File: tb/tb_stats_registers_controller.sv
// Directed bench: 32-bit, 4-channel instance at base 0x100 and a 4-bit, 2-channel instance at base 0.
module tb_stats_registers_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] msg_a = '0;
    logic [1:0] msg_b = '0;
    logic       irq_a, irq_b;
    int         n_chk = 0;
    int         n_fail = 0;
    logic [31:0] d;
    logic        v;

    always #5 clk = ~clk;

    stats_registers_controller_if #(.ADDR_W(16), .DATA_W(32)) bus_a ();
    stats_registers_controller_if #(.ADDR_W(16), .DATA_W(32)) bus_b ();

    stats_registers_controller #(.ADDR_BASE(16'h0100), .NUM_CH(4), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .msg_enter(msg_a), .bus(bus_a), .irq(irq_a));
    stats_registers_controller #(.ADDR_BASE(0), .NUM_CH(2), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .msg_enter(msg_b), .bus(bus_b), .irq(irq_b));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bus tasks start and end at posedge+1; sel picks the instance.
    task automatic wr(input bit sel, input logic [15:0] addr, input logic [31:0] data);
        if (sel) begin
            bus_b.reg_address = addr; bus_b.reg_writedata = data; bus_b.reg_write = 1'b1;
        end else begin
            bus_a.reg_address = addr; bus_a.reg_writedata = data; bus_a.reg_write = 1'b1;
        end
        @(posedge clk); #1;
        bus_a.reg_write = 1'b0; bus_b.reg_write = 1'b0;
    endtask

    task automatic rd(input bit sel, input logic [15:0] addr, output logic [31:0] data, output logic valid);
        if (sel) begin
            bus_b.reg_address = addr; bus_b.reg_read = 1'b1;
        end else begin
            bus_a.reg_address = addr; bus_a.reg_read = 1'b1;
        end
        @(posedge clk); #1;
        bus_a.reg_read = 1'b0; bus_b.reg_read = 1'b0;
        data  = sel ? bus_b.reg_readdata : bus_a.reg_readdata;
        valid = sel ? bus_b.reg_readdatavalid : bus_a.reg_readdatavalid;
    endtask

    initial begin
        bus_a.reg_address = '0; bus_a.reg_write = 0; bus_a.reg_writedata = '0; bus_a.reg_read = 0;
        bus_b.reg_address = '0; bus_b.reg_write = 0; bus_b.reg_writedata = '0; bus_b.reg_read = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata", bus_a.reg_readdata, 32'h0);
        chk("rst_rvalid", {31'b0, bus_a.reg_readdatavalid}, 32'h0);
        chk("rst_irq", {31'b0, irq_a}, 32'h0);
        rst = 1'b0;

        rd(0, 16'h0100, d, v);
        chk("id_valid", {31'b0, v}, 32'h1);
        chk("id_data", d, 32'h5354_0001);
        @(posedge clk); #1;
        chk("id_valid_pulse", {31'b0, bus_a.reg_readdatavalid}, 32'h0);
        rd(0, 16'h0105, d, v);
        chk("scratch1_rst", d, 32'h0);
        rd(0, 16'h0101, d, v);
        chk("ctrl_rst", d, 32'h1);

        wr(0, 16'h0104, 32'hDEAD_BEEF);
        wr(0, 16'h013F, 32'h1234_5678);
        rd(0, 16'h013F, d, v);
        chk("hole_valid", {31'b0, v}, 32'h1);
        chk("hole_data", d, 32'h0);
        rd(0, 16'h0104, d, v);
        chk("scratch0", d, 32'hDEAD_BEEF);
        rd(0, 16'h0140, d, v);
        chk("above_win_valid", {31'b0, v}, 32'h0);
        chk("rdata_hold", d, 32'hDEAD_BEEF);
        rd(0, 16'h00FF, d, v);
        chk("below_win_valid", {31'b0, v}, 32'h0);

        msg_a = 4'b0010;
        repeat (10) @(posedge clk);
        #1 msg_a = '0;
        rd(0, 16'h0121, d, v);
        chk("cnt1_en", d, 32'd10);
        rd(0, 16'h0120, d, v);
        chk("cnt0_idle", d, 32'd0);
        wr(0, 16'h0101, 32'h0);
        msg_a = 4'b0010;
        repeat (10) @(posedge clk);
        #1 msg_a = '0;
        rd(0, 16'h0121, d, v);
        chk("cnt1_dis", d, 32'd10);
        wr(0, 16'h0101, 32'h1);

        // Same-cycle read and write of scratch1.
        bus_a.reg_address = 16'h0105; bus_a.reg_writedata = 32'hA5A5_0001;
        bus_a.reg_read = 1'b1; bus_a.reg_write = 1'b1;
        @(posedge clk); #1;
        bus_a.reg_read = 1'b0; bus_a.reg_write = 1'b0;
        chk("rw_old", bus_a.reg_readdata, 32'h0);
        rd(0, 16'h0105, d, v);
        chk("rw_new", d, 32'hA5A5_0001);

        wr(0, 16'h0101, 32'h3);
        msg_a = 4'b0001;
        repeat (5) @(posedge clk);
        #1;
        rd(0, 16'h0120, d, v);
        chk("cor_first", d, 32'd5);
        rd(0, 16'h0120, d, v);
        chk("cor_b2b", d, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        rd(0, 16'h0120, d, v);
        chk("cor_gap", d, 32'd4);
        msg_a = '0;
        wr(0, 16'h0101, 32'h1);

        msg_a = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        wr(0, 16'h0101, 32'h9);
        msg_a = '0;
        for (int ch = 0; ch < 4; ch++) begin
            rd(0, 16'(16'h0120 + ch), d, v);
            chk($sformatf("clear_all_cnt%0d", ch), d, 32'h0);
        end
        rd(0, 16'h0101, d, v);
        chk("ctrl_after_clear", d, 32'h1);

        // Second instance: 4-bit counters.
        msg_b = 2'b01;
        repeat (17) @(posedge clk);
        #1 msg_b = '0;
        rd(1, 16'h0020, d, v);
        chk("wrap_cnt", d, 32'd1);
        rd(1, 16'h0002, d, v);
        chk("wrap_status", d, 32'h1);
        rd(1, 16'h0021, d, v);
        chk("wrap_cnt1", d, 32'd0);
        wr(1, 16'h0001, 32'h9);
        wr(1, 16'h0001, 32'h5);
        msg_b = 2'b01;
        repeat (17) @(posedge clk);
        #1 msg_b = '0;
        rd(1, 16'h0020, d, v);
        chk("sat_cnt", d, 32'd15);
        rd(1, 16'h0002, d, v);
        chk("sat_status", d, 32'h1);
        chk("irq_masked", {31'b0, irq_b}, 32'h0);
        wr(1, 16'h0003, 32'h1);
        chk("irq_lag", {31'b0, irq_b}, 32'h0);
        @(posedge clk); #1;
        chk("irq_set", {31'b0, irq_b}, 32'h1);
        wr(1, 16'h0002, 32'h1);
        chk("irq_hold", {31'b0, irq_b}, 32'h1);
        @(posedge clk); #1;
        chk("irq_drop", {31'b0, irq_b}, 32'h0);
        rd(1, 16'h0002, d, v);
        chk("status_w1c", d, 32'h0);

        // Reset coinciding with a read drops it.
        bus_a.reg_address = 16'h0100; bus_a.reg_read = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        bus_a.reg_read = 1'b0;
        chk("rst_read_valid", {31'b0, bus_a.reg_readdatavalid}, 32'h0);
        @(posedge clk); #1;
        chk("rst_read_valid2", {31'b0, bus_a.reg_readdatavalid}, 32'h0);
        rst = 1'b0;
        rd(0, 16'h0104, d, v);
        chk("scratch_after_rst", d, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
